mmio_bus_router: RTL and testbench

MMIO_BUS_ROUTER -- requirements
Module: mmio_bus_router

---
 rtl/mmio_bus_router_pkg.sv | 32 +++
 rtl/mmio_bus_router_if.sv | 31 +++
 rtl/mmio_bus_router_irq_pacer.sv | 85 ++++++++
 rtl/mmio_bus_router.sv | 149 ++++++++++++++
 tb/tb_mmio_bus_router.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mmio_bus_router_pkg.sv
// Shared MMIO bus constants: opcodes, status codes, FSM states and
// exception word builders used by the router and its IRQ pacer.
package mmio_bus_router_pkg;

    localparam logic [4:0] UMEM_OPM_READY = 5'h00;
    localparam logic [4:0] UMEM_OPM_RD_SL = 5'h0A;
    localparam logic [4:0] UMEM_OPM_RD_Q  = 5'h0B;
    localparam logic [4:0] UMEM_OPM_WR_SL = 5'h12;
    localparam logic [4:0] UMEM_OPM_WR_Q  = 5'h13;

    localparam logic [1:0] UMEM_OK_READY = 2'b00;
    localparam logic [1:0] UMEM_OK_OK    = 2'b01;
    localparam logic [1:0] UMEM_OK_HOLD  = 2'b10;

    localparam logic [3:0] EXC_IRQ   = 4'hC;
    localparam logic [3:0] EXC_FAULT = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    function automatic logic [63:0] irq_word(input logic [1:0] port);
        return {48'h0, EXC_IRQ, 10'h000, port};
    endfunction

    function automatic logic [63:0] fault_word(input logic [31:0] addr);
        return {addr, 16'h0000, EXC_FAULT, 12'h001};
    endfunction

endpackage

// File: rtl/mmio_bus_router_if.sv
// Upstream MMIO request bus plus the four-port device-side bus.
interface mmio_bus_router_if;

    logic [31:0]  mmioAddr;
    logic [4:0]   mmioOpm;
    logic [63:0]  mmioOutData;
    logic [63:0]  mmioInData;
    logic [1:0]   mmioOK;
    logic [63:0]  mmioExcIn;
    logic [31:0]  devAddr;
    logic [63:0]  devOutData;
    logic [19:0]  devOpm;
    logic [255:0] devInData;
    logic [7:0]   devOK;
    logic [3:0]   devIrq;

    modport master (
        output mmioAddr, mmioOpm, mmioOutData,
        output devInData, devOK, devIrq,
        input  mmioInData, mmioOK, mmioExcIn,
        input  devAddr, devOutData, devOpm
    );

    modport slave (
        input  mmioAddr, mmioOpm, mmioOutData,
        input  devInData, devOK, devIrq,
        output mmioInData, mmioOK, mmioExcIn,
        output devAddr, devOutData, devOpm
    );

endinterface

// File: rtl/mmio_bus_router_irq_pacer.sv
// Captures device IRQ edges and bus faults, emitting one exception word
// at a time, fault first then lowest port, spaced by EXC_GAP cycles.
module mmio_irq_pacer
    import mmio_bus_router_pkg::*;
#(
    parameter logic [3:0] EXC_GAP = 4'd8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  irq,
    input  logic        fault_set,
    input  logic [31:0] fault_addr,
    output logic [63:0] exc
);

    // Counting down from EXC_GAP-1 puts consecutive pulses EXC_GAP apart.
    localparam logic [3:0] GAP_LOAD =
        (EXC_GAP == 4'd0) ? 4'd0 : EXC_GAP - 4'd1;

    logic [3:0]  irq_prev;
    logic [3:0]  pend;
    logic        fault_pend;
    logic [31:0] fault_addr_q;
    logic [3:0]  gap;
    logic [3:0]  gap_n;
    logic [3:0]  clr;
    logic        clr_fault;
    logic [63:0] word;

    always_comb begin
        word      = '0;
        clr       = '0;
        clr_fault = 1'b0;
        gap_n     = (gap == 4'd0) ? 4'd0 : gap - 4'd1;
        if (gap == 4'd0) begin
            priority case (1'b1)
                fault_pend: begin
                    word      = fault_word(fault_addr_q);
                    clr_fault = 1'b1;
                    gap_n     = GAP_LOAD;
                end
                pend[0]: begin
                    word   = irq_word(2'd0);
                    clr[0] = 1'b1;
                    gap_n  = GAP_LOAD;
                end
                pend[1]: begin
                    word   = irq_word(2'd1);
                    clr[1] = 1'b1;
                    gap_n  = GAP_LOAD;
                end
                pend[2]: begin
                    word   = irq_word(2'd2);
                    clr[2] = 1'b1;
                    gap_n  = GAP_LOAD;
                end
                pend[3]: begin
                    word   = irq_word(2'd3);
                    clr[3] = 1'b1;
                    gap_n  = GAP_LOAD;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_prev     <= '0;
            pend         <= '0;
            fault_pend   <= 1'b0;
            fault_addr_q <= '0;
            gap          <= '0;
            exc          <= '0;
        end else begin
            irq_prev   <= irq;
            pend       <= (pend & ~clr) | (irq & ~irq_prev);
            fault_pend <= (fault_pend & ~clr_fault) | fault_set;
            if (fault_set) fault_addr_q <= fault_addr;
            gap        <= gap_n;
            exc        <= word;
        end
    end

endmodule

// File: rtl/mmio_bus_router.sv
// Routes upstream MMIO requests to one of four address windows, with a
// per-request timeout that raises a fault exception.
module mmio_bus_router
    import mmio_bus_router_pkg::*;
#(
    parameter logic [11:0] BASE0   = 12'h00A,
    parameter logic [11:0] BASE1   = 12'h00B,
    parameter logic [11:0] BASE2   = 12'h00C,
    parameter logic [11:0] BASE3   = 12'h00D,
    parameter logic [7:0]  TIMEOUT = 8'd200,
    parameter logic [3:0]  EXC_GAP = 4'd8
) (
    input logic clock,
    input logic reset,
    mmio_bus_router_if.slave bus
);

    state_t      state, state_n;
    logic [1:0]  sel, sel_n;
    logic [31:0] addr_q, addr_n;
    logic [63:0] wdata_q, wdata_n;
    logic [63:0] rdata_q, rdata_n;
    logic [1:0]  ok_q, ok_n;
    logic [7:0]  timer, timer_n;
    logic [19:0] opm_out, opm_out_n;
    logic        fault_set;
    logic        hit;
    logic [1:0]  hit_sel;
    logic [11:0] base [4];
    logic [1:0]  ok_sel;
    logic [63:0] rd_sel;

    assign base[0] = BASE0;
    assign base[1] = BASE1;
    assign base[2] = BASE2;
    assign base[3] = BASE3;

    always_comb begin
        hit     = 1'b0;
        hit_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.mmioAddr[27:16] == base[i]) begin
                hit     = 1'b1;
                hit_sel = 2'(i);
            end
        end
    end

    assign ok_sel = bus.devOK[{sel, 1'b0} +: 2];
    assign rd_sel = bus.devInData[{sel, 6'd0} +: 64];

    always_comb begin
        state_n   = state;
        sel_n     = sel;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        rdata_n   = rdata_q;
        ok_n      = ok_q;
        timer_n   = timer;
        opm_out_n = opm_out;
        fault_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.mmioOpm != UMEM_OPM_READY) begin
                    addr_n  = bus.mmioAddr;
                    wdata_n = bus.mmioOutData;
                    sel_n   = hit_sel;
                    ok_n    = UMEM_OK_HOLD;
                    if (hit) begin
                        for (int i = 0; i < 4; i++) begin
                            opm_out_n[5*i +: 5] = (hit_sel == 2'(i)) ?
                                bus.mmioOpm : UMEM_OPM_READY;
                        end
                        timer_n = '0;
                        state_n = WAIT;
                    end else begin
                        rdata_n = '0;
                        state_n = DONE;
                    end
                end
            end
            WAIT: begin
                if (ok_sel == UMEM_OK_OK) begin
                    rdata_n   = rd_sel;
                    opm_out_n = '0;
                    ok_n      = UMEM_OK_OK;
                    state_n   = DONE;
                end else if (timer == TIMEOUT - 8'd1) begin
                    rdata_n   = '1;
                    opm_out_n = '0;
                    ok_n      = UMEM_OK_OK;
                    fault_set = 1'b1;
                    state_n   = DONE;
                end else begin
                    timer_n = timer + 8'd1;
                end
            end
            DONE: begin
                if (bus.mmioOpm == UMEM_OPM_READY) begin
                    ok_n    = UMEM_OK_READY;
                    state_n = IDLE;
                end else begin
                    ok_n = UMEM_OK_OK;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            sel     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ok_q    <= UMEM_OK_READY;
            timer   <= '0;
            opm_out <= '0;
        end else begin
            state   <= state_n;
            sel     <= sel_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rdata_q <= rdata_n;
            ok_q    <= ok_n;
            timer   <= timer_n;
            opm_out <= opm_out_n;
        end
    end

    assign bus.mmioOK     = ok_q;
    assign bus.mmioInData = rdata_q;
    assign bus.devAddr    = addr_q;
    assign bus.devOutData = wdata_q;
    assign bus.devOpm     = opm_out;

    mmio_irq_pacer #(
        .EXC_GAP(EXC_GAP)
    ) u_pacer (
        .clock     (clock),
        .reset     (reset),
        .irq       (bus.devIrq),
        .fault_set (fault_set),
        .fault_addr(addr_q),
        .exc       (bus.mmioExcIn)
    );

endmodule

// File: tb/tb_mmio_bus_router.sv
// Directed and randomized checks of mmio_bus_router against a
// window-lookup reference model and latency-programmable device models.
module tb_mmio_bus_router;
    import mmio_bus_router_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mmio_bus_router_if bus();

    mmio_bus_router dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    int          dev_lat  [4];
    logic [63:0] dev_data [4];
    int          dev_cnt  [4];

    typedef struct {
        int          c;
        logic [63:0] w;
    } exc_t;
    exc_t excq[$];

    logic [4:0] ops [4] = '{UMEM_OPM_RD_SL, UMEM_OPM_RD_Q,
                            UMEM_OPM_WR_SL, UMEM_OPM_WR_Q};

    always @(posedge clock) cyc++;

    // Device models answer OK once their opcode has been visible lat+1 cycles.
    always @(negedge clock) begin
        if (!reset && bus.mmioExcIn !== 64'h0)
            excq.push_back('{cyc, bus.mmioExcIn});
        for (int i = 0; i < 4; i++) begin
            if (!reset && bus.devOpm[5*i +: 5] !== 5'h00) begin
                dev_cnt[i]++;
                if (dev_lat[i] >= 0 && dev_cnt[i] > dev_lat[i]) begin
                    bus.devOK[2*i +: 2]      = UMEM_OK_OK;
                    bus.devInData[64*i +: 64] = dev_data[i];
                end else begin
                    bus.devOK[2*i +: 2] = UMEM_OK_HOLD;
                end
            end else begin
                dev_cnt[i]               = 0;
                bus.devOK[2*i +: 2]      = UMEM_OK_READY;
                bus.devInData[64*i +: 64] = 64'h0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int port_of(input logic [31:0] a);
        if (a[27:16] >= 12'h00A && a[27:16] <= 12'h00D)
            return int'(a[27:16]) - 10;
        return -1;
    endfunction

    task automatic do_req(input logic [31:0] a, input logic [4:0] op,
                          input logic [63:0] d, input int lat,
                          input logic [63:0] rd, input int bound);
        int          p;
        int          n;
        bit          got;
        logic [63:0] exp;
        logic [19:0] exp_opm;
        p = port_of(a);
        if (p >= 0) begin
            dev_lat[p]  = lat;
            dev_data[p] = rd;
        end
        exp = (p < 0) ? 64'h0 : ((lat < 0) ? '1 : rd);
        exp_opm = '0;
        if (p >= 0) exp_opm[5*p +: 5] = op;
        bus.mmioAddr    = a;
        bus.mmioOpm     = op;
        bus.mmioOutData = d;
        @(negedge clock);
        check("accept_hold", 64'(bus.mmioOK), 64'(UMEM_OK_HOLD));
        check("dev_opm", 64'(bus.devOpm), 64'(exp_opm));
        if (p >= 0) begin
            check("dev_addr", 64'(bus.devAddr), 64'(a));
            check("dev_wdata", bus.devOutData, d);
        end
        n   = 0;
        got = 0;
        while (n < bound && !got) begin
            if (bus.mmioOK === UMEM_OK_OK) got = 1;
            else begin
                @(negedge clock);
                n++;
            end
        end
        check("ok_seen", 64'(got), 64'd1);
        check("rdata", bus.mmioInData, exp);
        check("dev_opm_idle", 64'(bus.devOpm), 64'h0);
        @(negedge clock);
        check("ok_held", 64'(bus.mmioOK), 64'(UMEM_OK_OK));
        check("rdata_held", bus.mmioInData, exp);
        bus.mmioOpm = UMEM_OPM_READY;
        @(negedge clock);
        check("ok_ready", 64'(bus.mmioOK), 64'(UMEM_OK_READY));
        @(negedge clock);
    endtask

    initial begin
        int          p;
        logic [11:0] win;
        logic [31:0] a;
        reset           = 1'b1;
        bus.mmioAddr    = '0;
        bus.mmioOpm     = UMEM_OPM_READY;
        bus.mmioOutData = '0;
        bus.devIrq      = '0;
        for (int i = 0; i < 4; i++) begin
            dev_lat[i]  = 0;
            dev_data[i] = '0;
            dev_cnt[i]  = 0;
        end
        repeat (3) @(negedge clock);
        check("rst_ok", 64'(bus.mmioOK), 64'(UMEM_OK_READY));
        check("rst_devopm", 64'(bus.devOpm), 64'h0);
        check("rst_exc", bus.mmioExcIn, 64'h0);
        check("rst_rdata", bus.mmioInData, 64'h0);
        reset = 1'b0;
        @(negedge clock);

        do_req(32'h000A_0010, UMEM_OPM_RD_Q, 64'h0, 3,
               64'h1122_3344_5566_7788, 20);
        do_req(32'h0001_0000, UMEM_OPM_WR_SL, 64'hDEAD_BEEF_0BAD_F00D, 0,
               64'h0, 2);

        for (int t = 0; t < 20; t++) begin
            p   = $urandom_range(0, 4);
            win = (p < 4) ? 12'h00A + 12'(p) : 12'h100 + 12'($urandom_range(0, 255));
            a   = {4'($urandom), win, 16'($urandom)};
            do_req(a, ops[$urandom_range(0, 3)], {$urandom, $urandom},
                   $urandom_range(0, 5), {$urandom, $urandom}, 20);
        end
        check("no_exc_random", 64'(excq.size()), 64'd0);

        do_req(32'h000C_1234, UMEM_OPM_RD_SL, 64'h0, -1, 64'h0, 260);
        repeat (3) @(negedge clock);
        check("fault_count", 64'(excq.size()), 64'd1);
        if (excq.size() > 0)
            check("fault_word", excq[0].w, {32'h000C_1234, 32'h0000_E001});
        excq.delete();

        repeat (10) @(negedge clock);
        bus.devIrq = 4'b1010;
        repeat (30) @(negedge clock);
        check("irq_count", 64'(excq.size()), 64'd2);
        if (excq.size() >= 2) begin
            check("irq_first", excq[0].w, 64'h0000_0000_0000_C001);
            check("irq_second", excq[1].w, 64'h0000_0000_0000_C003);
            check("irq_gap", 64'(excq[1].c - excq[0].c), 64'd8);
        end
        bus.devIrq = 4'b0000;
        excq.delete();

        dev_lat[1]   = -1;
        bus.mmioAddr = 32'h000B_0040;
        bus.mmioOpm  = UMEM_OPM_RD_Q;
        repeat (5) @(negedge clock);
        check("midwait_opm", 64'(bus.devOpm), 64'(20'h0000_B) << 5);
        reset = 1'b1;
        @(negedge clock);
        check("rstw_devopm", 64'(bus.devOpm), 64'h0);
        check("rstw_ok", 64'(bus.mmioOK), 64'(UMEM_OK_READY));
        check("rstw_exc", bus.mmioExcIn, 64'h0);
        bus.mmioOpm = UMEM_OPM_READY;
        reset       = 1'b0;
        @(negedge clock);
        do_req(32'h000B_0040, UMEM_OPM_RD_Q, 64'h0, 2,
               64'hCAFE_F00D_1234_5678, 20);
        check("no_exc_end", 64'(excq.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
